if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

Instruction-fetch control stage that owns the program counter and drives Icache requests. It sits directly upstream of the flow controller: it produces `if_req_Icache_o` and consumes `fc_stall_if_i`, `fc_jump_flag_if_i` and `fc_jump_pc_if_i`. It presents PC and instruction to the IF/ID register. Redirects that arrive during an Icache miss are captured, so no jump is lost while a refill is in flight.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded by reset.
- `NOP_INST`, 32'h0000_0013, instruction presented whenever `if_valid_o`=0.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fc_stall_if_i`  in  1  hold PC (flow-control stall).
- `fc_jump_flag_if_i`  in  1  redirect request.
- `fc_jump_pc_if_i`  in  32  redirect target.
- `Icache_hit_i`  in  1  same-cycle hit for the current request.
- `Icache_inst_i`  in  32  instruction, valid when hit.
- `bc_Icache_ready_i`  in  1  one-cycle pulse: refill complete.
- `if_req_Icache_o`  out  1  fetch request.
- `if_addr_Icache_o`  out  32  fetch address (= PC).
- `if_pc_o`  out  32  PC of presented instruction.
- `if_inst_o`  out  32  instruction to IF/ID.
- `if_valid_o`  out  1  `if_inst_o` is a real fetched instruction.

## Operation
- State register, 2 states:
  - FETCH: request issued every cycle.
  - MISS: waiting on refill, no request.
- Registers: `pc`[31:0], `pend_flag`, `pend_pc`[31:0].
- `if_addr_Icache_o`=`if_pc_o`=`pc`.
- `if_req_Icache_o`=1 in FETCH, 0 in MISS.
- `if_valid_o`=1 only in FETCH with `Icache_hit_i`=1 and `fc_jump_flag_if_i`=0.
- `if_inst_o`=`Icache_inst_i` when `if_valid_o`=1, else `NOP_INST`.
- FETCH, evaluated in priority order:
  1. Jump: `pc`<=`fc_jump_pc_if_i`. Stay in FETCH. Outputs a bubble. Jump wins over stall and over miss.
  2. Miss (`Icache_hit_i`=0): go to MISS, hold `pc`.
  3. Stall with hit: hold `pc`. The same instruction is re-presented next cycle.
  4. Hit, no stall: `pc`<=`pc`+4.
- MISS:
  - Jump seen: `pend_flag`<=1, `pend_pc`<=`fc_jump_pc_if_i`. The latest jump overwrites any earlier pending one.
  - `bc_Icache_ready_i`=1: return to FETCH, clear `pend_flag`. `pc`<=`pend_pc` if a redirect is pending (including one arriving in this same cycle, which takes precedence); otherwise `pc` is held and the same address is re-requested.
  - Stall is ignored in MISS (no request is outstanding).
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0. Low two bits are carried through unchanged; alignment is not checked.

## Timing
- Reset (`rst`=1 at an edge):
  - state=FETCH, `pc`=`RESET_PC`, `pend_flag`=0, `pend_pc`=0.
  - Outputs the cycle after: `if_req_Icache_o`=1, `if_addr_Icache_o`=`if_pc_o`=`RESET_PC`, `if_valid_o`=0 unless hit, `if_inst_o`=`NOP_INST` unless hit.
- Reset mid-miss abandons the refill and discards the pending redirect. A subsequent `bc_Icache_ready_i` pulse in FETCH is ignored.
- All outputs are combinational from state, `pc` and same-cycle inputs. Hit path has zero added latency; PC advances once per hit cycle.
- Miss penalty: 1 cycle to enter MISS, N cycles of refill, 1 re-request cycle (now a hit).
- Redirect latency: target requested on the cycle after the jump (FETCH), or on the cycle after `bc_Icache_ready_i` (MISS).
- A stall held across many cycles re-presents the identical PC/instruction each cycle. There is no duplicate advance.

## Structure
- Shared package: `RESET_PC`/`NOP_INST` defaults, state encoding (FETCH=1'b0, MISS=1'b1), `INST_W`=32.
- No sub-module is needed. The PC-next mux is kept inline as a single combinational block feeding the `pc` register.

## Test plan
- Reset release, cache always hits: `pc` steps 0, 4, 8, 12 with `if_valid_o`=1 each cycle; outputs equal `RESET_PC`/`NOP_INST` during reset.
- Miss at 0x10, ready pulse after 5 cycles: `if_req_Icache_o` low 5 cycles, 0x10 re-requested, hit, then 0x14.
- Jump to 0x200 during miss, ready 3 cycles later: next request is 0x200, not the missed address; `pend_flag` clears.
- Stall 4 cycles at 0x20 with hit: 0x20 presented 4+1 times, then 0x24; jump to 0x80 during stall is taken immediately with `if_valid_o`=0.
- Wrap-around: `pc`=0xFFFF_FFFC, hit, no stall: next `pc`=0x0000_0000.
- `rst` asserted in MISS with pending redirect to 0x300: `pc`=`RESET_PC`, state FETCH; a late `bc_Icache_ready_i` pulse has no effect.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch control stage.
//   INST_W   : instruction / address width
//   RESET_PC : program counter value loaded by reset
//   NOP_INST : instruction presented whenever no real fetch is valid
//   fetch_state_e : FETCH (request every cycle) / MISS (waiting on refill)
package if_fetch_ctrl_pkg;

  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    MISS  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch control: owns the PC, issues Icache requests and
// presents PC/instruction to the IF/ID register. Redirects arriving during
// an Icache miss are held in a pending register and applied on refill.
//
// Ports
//   clk                in   clock, all state on rising edge
//   rst                in   synchronous active-high reset
//   fc_stall_if_i      in   hold PC (ignored while in MISS)
//   fc_jump_flag_if_i  in   redirect request
//   fc_jump_pc_if_i    in   redirect target
//   Icache_hit_i       in   same-cycle hit for the current request
//   Icache_inst_i      in   instruction, valid when hit
//   bc_Icache_ready_i  in   one-cycle pulse, refill complete
//   if_req_Icache_o    out  fetch request (FETCH only)
//   if_addr_Icache_o   out  fetch address (= PC)
//   if_pc_o            out  PC of presented instruction
//   if_inst_o          out  instruction to IF/ID (NOP when not valid)
//   if_valid_o         out  if_inst_o is a real fetched instruction
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fc_stall_if_i,
  input  logic              fc_jump_flag_if_i,
  input  logic [INST_W-1:0] fc_jump_pc_if_i,
  input  logic              Icache_hit_i,
  input  logic [INST_W-1:0] Icache_inst_i,
  input  logic              bc_Icache_ready_i,
  output logic              if_req_Icache_o,
  output logic [INST_W-1:0] if_addr_Icache_o,
  output logic [INST_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic              if_valid_o
);

  fetch_state_e      state, state_n;
  logic [INST_W-1:0] pc, pc_n;
  logic              pend_flag, pend_flag_n;
  logic [INST_W-1:0] pend_pc, pend_pc_n;

  // Outputs are purely combinational so a hit costs no extra cycle.
  always_comb begin
    if_req_Icache_o  = (state == FETCH);
    if_addr_Icache_o = pc;
    if_pc_o          = pc;
    // A jump in the same cycle turns the fetched word into a bubble.
    if_valid_o       = (state == FETCH) && Icache_hit_i && !fc_jump_flag_if_i;
    if_inst_o        = if_valid_o ? Icache_inst_i : NOP_INST;
  end

  // Next-state / PC-next mux.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_n     = state;
    pc_n        = pc;
    pend_flag_n = pend_flag;
    pend_pc_n   = pend_pc;

    unique case (state)
      FETCH: begin
        if (fc_jump_flag_if_i) begin
          pc_n = fc_jump_pc_if_i;
        end else if (!Icache_hit_i) begin
          state_n = MISS;
        end else if (!fc_stall_if_i) begin
          pc_n = pc + 32'd4;       // modulo 2^32, low bits carried through
        end
      end

      MISS: begin
        // Latest redirect wins; stall is irrelevant with no request outstanding.
        if (fc_jump_flag_if_i) begin
          pend_flag_n = 1'b1;
          pend_pc_n   = fc_jump_pc_if_i;
        end
        if (bc_Icache_ready_i) begin
          state_n     = FETCH;
          pend_flag_n = 1'b0;
          if (fc_jump_flag_if_i) begin
            pc_n = fc_jump_pc_if_i;
          end else if (pend_flag) begin
            pc_n = pend_pc;
          end
        end
      end

      default: state_n = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      pend_flag <= 1'b0;
      pend_pc   <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      pend_flag <= pend_flag_n;
      pend_pc   <= pend_pc_n;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl. Each cycle a stimulus row is driven
// on the falling edge, the expected outputs are pushed to a scoreboard and
// popped/compared shortly afterwards, before the next rising edge.
module tb_if_fetch_ctrl;
  import if_fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fc_stall_if_i;
  logic        fc_jump_flag_if_i;
  logic [31:0] fc_jump_pc_if_i;
  logic        Icache_hit_i;
  logic [31:0] Icache_inst_i;
  logic        bc_Icache_ready_i;
  logic        if_req_Icache_o;
  logic [31:0] if_addr_Icache_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  if_fetch_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .fc_stall_if_i     (fc_stall_if_i),
    .fc_jump_flag_if_i (fc_jump_flag_if_i),
    .fc_jump_pc_if_i   (fc_jump_pc_if_i),
    .Icache_hit_i      (Icache_hit_i),
    .Icache_inst_i     (Icache_inst_i),
    .bc_Icache_ready_i (bc_Icache_ready_i),
    .if_req_Icache_o   (if_req_Icache_o),
    .if_addr_Icache_o  (if_addr_Icache_o),
    .if_pc_o           (if_pc_o),
    .if_inst_o         (if_inst_o),
    .if_valid_o        (if_valid_o)
  );

  // One cycle of stimulus plus the outputs it must produce.
  typedef struct {
    logic        rst;
    logic        stall;
    logic        jump;
    logic [31:0] jpc;
    logic        hit;
    logic        ready;
    logic        req;
    logic [31:0] pc;
    logic        valid;
  } stim_t;

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // Distinct instruction word per address so a wrong PC shows up in inst too.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic drive_cycle(input stim_t s);
    exp_t x;
    @(negedge clk);
    rst               = s.rst;
    fc_stall_if_i     = s.stall;
    fc_jump_flag_if_i = s.jump;
    fc_jump_pc_if_i   = s.jpc;
    Icache_hit_i      = s.hit;
    Icache_inst_i     = s.hit ? inst_of(s.pc) : 32'hBAD0_BAD0;
    bc_Icache_ready_i = s.ready;
    x.req   = s.req;
    x.pc    = s.pc;
    x.valid = s.valid;
    x.inst  = s.valid ? inst_of(s.pc) : NOP_INST;
    sb.push_back(x);
    #2;
  endtask

  task automatic test_reset();
    stim_t t [2];
    // Two edges with reset held so state is defined before sampling.
    @(negedge clk);
    @(negedge clk);
    t = '{
      '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0}
    };
    foreach (t[i]) begin
      drive_cycle(t[i]);
      e = sb.pop_front();
      tests++;
      if ({if_req_Icache_o, if_addr_Icache_o, if_pc_o, if_valid_o, if_inst_o} !==
          {e.req, e.pc, e.pc, e.valid, e.inst}) begin
        fails++;
        $display("FAIL reset[%0d]: got req=%b addr=%h pc=%h valid=%b inst=%h, want req=%b pc=%h valid=%b inst=%h",
                 i, if_req_Icache_o, if_addr_Icache_o, if_pc_o, if_valid_o, if_inst_o,
                 e.req, e.pc, e.valid, e.inst);
      end
    end
  endtask

  task automatic test_hit_stream();
    stim_t t [4];
    for (int i = 0; i < 4; i++)
      t[i] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'(i * 4), 1'b1};
    foreach (t[i]) begin
      drive_cycle(t[i]);
      e = sb.pop_front();
      tests++;
      if ({if_req_Icache_o, if_addr_Icache_o, if_pc_o, if_valid_o, if_inst_o} !==
          {e.req, e.pc, e.pc, e.valid, e.inst}) begin
        fails++;
        $display("FAIL hit_stream[%0d]: got req=%b addr=%h pc=%h valid=%b inst=%h, want req=%b pc=%h valid=%b inst=%h",
                 i, if_req_Icache_o, if_addr_Icache_o, if_pc_o, if_valid_o, if_inst_o,
                 e.req, e.pc, e.valid, e.inst);
      end
    end
  endtask

  task automatic test_miss();
    stim_t t [8];
    t = '{
      '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0},  // miss detected
      '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0},
      '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h10, 1'b0},  // stray hit in MISS
      '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0},  // stall ignored
      '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0},
      '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h10, 1'b0},  // refill done
      '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b1},  // re-request hits
      '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h14, 1'b1}
    };
    foreach (t[i]) begin
      drive_cycle(t[i]);
      e = sb.pop_front();
      tests++;
      if ({if_req_Icache_o, if_addr_Icache_o, if_pc_o, if_valid_o, if_inst_o} !==
          {e.req, e.pc, e.pc, e.valid, e.inst}) begin
        fails++;
        $display("FAIL miss[%0d]: got req=%b addr=%h pc=%h valid=%b inst=%h, want req=%b pc=%h valid=%b inst=%h",
                 i, if_req_Icache_o, if_addr_Icache_o, if_pc_o, if_valid_o, if_inst_o,
                 e.req, e.pc, e.valid, e.inst);
      end
    end
  endtask

  task automatic test_jump_in_miss();
    stim_t t [12];
    t = '{
      '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h18,  1'b0},  // miss
      '{1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h18,  1'b0},  // jump captured
      '{1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h18,  1'b0},  // overwrites
      '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h18,  1'b0},
      '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h18,  1'b0},  // ready
      '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h200, 1'b1},
      '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h204, 1'b1},
      '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h208, 1'b0},  // miss
      '{1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 32'h208, 1'b0},
      '{1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 32'h208, 1'b0},  // jump + ready
      '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h500, 1'b1},
      '{1'b0, 1'b0, 1'b1, 32'h20,  1'b0, 1'b0, 1'b1, 32'h504, 1'b0}   // jump beats miss
    };
    foreach (t[i]) begin
      drive_cycle(t[i]);
      e = sb.pop_front();
      tests++;
      if ({if_req_Icache_o, if_addr_Icache_o, if_pc_o, if_valid_o, if_inst_o} !==
          {e.req, e.pc, e.pc, e.valid, e.inst}) begin
        fails++;
        $display("FAIL jump_in_miss[%0d]: got req=%b addr=%h pc=%h valid=%b inst=%h, want req=%b pc=%h valid=%b inst=%h",
                 i, if_req_Icache_o, if_addr_Icache_o, if_pc_o, if_valid_o, if_inst_o,
                 e.req, e.pc, e.valid, e.inst);
      end
      if (i == 3 || i == 5) begin
        tests++;
        if (dut.pend_flag !== (i == 3)) begin
          fails++;
          $display("FAIL pend_flag[%0d]: got %b, want %b", i, dut.pend_flag, (i == 3));
        end
      end
    end
  endtask

  task automatic test_stall();
    stim_t t [8];
    for (int i = 0; i < 4; i++)
      t[i] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1};
    t[4] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h20, 1'b1};
    t[5] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h24, 1'b1};
    t[6] = '{1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 32'h28, 1'b0};  // jump beats stall
    t[7] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h80, 1'b1};
    foreach (t[i]) begin
      drive_cycle(t[i]);
      e = sb.pop_front();
      tests++;
      if ({if_req_Icache_o, if_addr_Icache_o, if_pc_o, if_valid_o, if_inst_o} !==
          {e.req, e.pc, e.pc, e.valid, e.inst}) begin
        fails++;
        $display("FAIL stall[%0d]: got req=%b addr=%h pc=%h valid=%b inst=%h, want req=%b pc=%h valid=%b inst=%h",
                 i, if_req_Icache_o, if_addr_Icache_o, if_pc_o, if_valid_o, if_inst_o,
                 e.req, e.pc, e.valid, e.inst);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t t [3];
    t = '{
      '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 32'h84,        1'b0},
      '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1},
      '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0,         1'b1}
    };
    foreach (t[i]) begin
      drive_cycle(t[i]);
      e = sb.pop_front();
      tests++;
      if ({if_req_Icache_o, if_addr_Icache_o, if_pc_o, if_valid_o, if_inst_o} !==
          {e.req, e.pc, e.pc, e.valid, e.inst}) begin
        fails++;
        $display("FAIL wrap[%0d]: got req=%b addr=%h pc=%h valid=%b inst=%h, want req=%b pc=%h valid=%b inst=%h",
                 i, if_req_Icache_o, if_addr_Icache_o, if_pc_o, if_valid_o, if_inst_o,
                 e.req, e.pc, e.valid, e.inst);
      end
    end
  endtask

  task automatic test_reset_in_miss();
    stim_t t [5];
    t = '{
      '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h4, 1'b0},  // miss
      '{1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h4, 1'b0},  // pending 0x300
      '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h4, 1'b0},  // reset in MISS
      '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h0, 1'b1},  // late ready
      '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h4, 1'b1}
    };
    foreach (t[i]) begin
      drive_cycle(t[i]);
      e = sb.pop_front();
      tests++;
      if ({if_req_Icache_o, if_addr_Icache_o, if_pc_o, if_valid_o, if_inst_o} !==
          {e.req, e.pc, e.pc, e.valid, e.inst}) begin
        fails++;
        $display("FAIL reset_in_miss[%0d]: got req=%b addr=%h pc=%h valid=%b inst=%h, want req=%b pc=%h valid=%b inst=%h",
                 i, if_req_Icache_o, if_addr_Icache_o, if_pc_o, if_valid_o, if_inst_o,
                 e.req, e.pc, e.valid, e.inst);
      end
      if (i == 3) begin
        tests++;
        if (dut.pend_flag !== 1'b0) begin
          fails++;
          $display("FAIL reset_pend_flag: got %b, want 0", dut.pend_flag);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst               = 1'b1;
    fc_stall_if_i     = 1'b0;
    fc_jump_flag_if_i = 1'b0;
    fc_jump_pc_if_i   = 32'h0;
    Icache_hit_i      = 1'b0;
    Icache_inst_i     = 32'h0;
    bc_Icache_ready_i = 1'b0;

    test_reset();
    test_hit_stream();
    test_miss();
    test_jump_in_miss();
    test_stall();
    test_wrap();
    test_reset_in_miss();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
